// File: rtl/grant_decoder.sv
// grant_decoder: registered one-hot decoder that holds a grant for HOLD cycles
// (or until early release), then forces GAP idle cycles before accepting again.
module grant_decoder #(
   parameter  int IDX_W = 3,
   parameter  int HOLD  = 4,
   parameter  int GAP   = 1,
   localparam int N     = 2**IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_none,
   input  logic             release_i,
   output logic [N-1:0]     grant,
   output logic             grant_active,
   output logic             done
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;
   localparam logic [7:0]   HOLD_C = 8'(HOLD - 1);
   localparam logic [7:0]   GAP_C  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
   localparam logic [N-1:0] ONE    = 1;
   state_t     r_state;
   logic [7:0] r_cnt;
   logic       w_end;
   assign in_ready = (r_state == S_IDLE);
   assign w_end    = (r_cnt == 8'd0) || release_i;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 8'd0;
         grant        <= '0;
         grant_active <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: if (in_valid) begin
               if (in_none) done <= 1'b1;
               else begin
                  r_state      <= S_GRANT;
                  grant        <= ONE << in_idx;
                  grant_active <= 1'b1;
                  r_cnt        <= HOLD_C;
               end
            end
            S_GRANT: if (w_end) begin
               r_state      <= (GAP > 0) ? S_GAP : S_IDLE;
               grant        <= '0;
               grant_active <= 1'b0;
               done         <= 1'b1;
               r_cnt        <= GAP_C;
            end else r_cnt <= r_cnt - 8'd1;
            default: if (r_cnt == 8'd0) r_state <= S_IDLE;
                     else r_cnt <= r_cnt - 8'd1;
         endcase
      end
   end
   a_onehot: assert property (@(posedge clk) disable iff (rst) $countones(grant) <= 1);
endmodule
